mem_wb_writeback: RTL and testbench

- MEM/WB pipeline register plus writeback-select logic for the MIPS core.
- Captures the memory-stage result, aligns and extends load data, and selects ALU, load or link data.
- Drives the register-file write port (we, addressW, data) and a forwarding tap for the upstream hazard logic.
- Counts retired instructions.

---
 rtl/mips_wb_pkg.sv | 12 +
 rtl/mem_wb_writeback_load_align.sv | 38 +++
 rtl/mem_wb_writeback.sv | 131 +++++++++++++
 tb/tb_mem_wb_writeback.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// Shared encodings and default widths for the MEM/WB writeback slice.
package mips_wb_pkg;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int REGFILE_WIDTH_DEF = 5;

  // Load-size encodings; 2'b11 is treated as a full word.
  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

endpackage

// File: rtl/mem_wb_writeback_load_align.sv
// Big-endian load-data alignment and sign/zero extension for lb/lbu/lh/lhu/lw.
module load_align
  import mips_wb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] raw_i,
  input  logic [1:0]            size_i,
  input  logic [1:0]            offset_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    // Offset 0 addresses the most significant byte lane.
    case (offset_i)
      2'd0: byte_sel = raw_i[DATA_WIDTH-1  -: 8];
      2'd1: byte_sel = raw_i[DATA_WIDTH-9  -: 8];
      2'd2: byte_sel = raw_i[DATA_WIDTH-17 -: 8];
      default: byte_sel = raw_i[DATA_WIDTH-25 -: 8];
    endcase
    half_sel = offset_i[1] ? raw_i[DATA_WIDTH-17 -: 16] : raw_i[DATA_WIDTH-1 -: 16];
  end

  always_comb begin
    data_o = raw_i;
    case (size_i)
      LS_BYTE: data_o = {{(DATA_WIDTH-8){~unsigned_i & byte_sel[7]}}, byte_sel};
      LS_HALF: data_o = {{(DATA_WIDTH-16){~unsigned_i & half_sel[15]}}, half_sel};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB stage register, writeback select and forwarding tap.
// Define WB_PERF_EN to build the retired-instruction counter; otherwise it reads 0.
module mem_wb_writeback
  import mips_wb_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int REGFILE_WIDTH = REGFILE_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_reg_write,
  input  logic                     in_mem_to_reg,
  input  logic                     in_link,
  input  logic [1:0]               in_load_size,
  input  logic                     in_load_unsigned,
  input  logic [1:0]               in_byte_offset,
  input  logic [DATA_WIDTH-1:0]    in_alu_result,
  input  logic [DATA_WIDTH-1:0]    in_mem_data,
  input  logic [DATA_WIDTH-1:0]    in_pc_plus8,
  input  logic [REGFILE_WIDTH-1:0] in_dest,
  output logic                     wb_we,
  output logic [REGFILE_WIDTH-1:0] wb_address,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     fwd_valid,
  output logic [REGFILE_WIDTH-1:0] fwd_address,
  output logic [DATA_WIDTH-1:0]    fwd_data,
  output logic [31:0]              retired_count
);

  logic                     valid_q, valid_d;
  logic                     fired_q, fired_d;
  logic                     reg_write_q, mem_to_reg_q, link_q, load_unsigned_q;
  logic [1:0]               load_size_q, byte_offset_q;
  logic [DATA_WIDTH-1:0]    alu_result_q, mem_data_q, pc_plus8_q;
  logic [REGFILE_WIDTH-1:0] dest_q;
  logic [DATA_WIDTH-1:0]    load_value;
  logic                     retire;

  // fired marks an instruction already presented once, so a stalled one writes only once.
  always_comb begin
    valid_d = valid_q;
    fired_d = fired_q;
    if (flush) begin
      valid_d = 1'b0;
      fired_d = 1'b0;
    end else if (stall) begin
      fired_d = fired_q | valid_q;
    end else begin
      valid_d = in_valid;
      fired_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= 1'b0;
      fired_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      link_q          <= 1'b0;
      load_unsigned_q <= 1'b0;
      load_size_q     <= LS_WORD;
      byte_offset_q   <= 2'b00;
      alu_result_q    <= '0;
      mem_data_q      <= '0;
      pc_plus8_q      <= '0;
      dest_q          <= '0;
    end else begin
      valid_q <= valid_d;
      fired_q <= fired_d;
      if (!flush && !stall) begin
        reg_write_q     <= in_reg_write;
        mem_to_reg_q    <= in_mem_to_reg;
        link_q          <= in_link;
        load_unsigned_q <= in_load_unsigned;
        load_size_q     <= in_load_size;
        byte_offset_q   <= in_byte_offset;
        alu_result_q    <= in_alu_result;
        mem_data_q      <= in_mem_data;
        pc_plus8_q      <= in_pc_plus8;
        dest_q          <= in_dest;
      end
    end
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .raw_i      (mem_data_q),
    .size_i     (load_size_q),
    .offset_i   (byte_offset_q),
    .unsigned_i (load_unsigned_q),
    .data_o     (load_value)
  );

  assign retire     = valid_q & ~fired_q;
  assign wb_we      = retire & reg_write_q & (dest_q != '0);
  assign wb_address = valid_q ? dest_q : '0;

  always_comb begin
    wb_data = '0;
    if (valid_q) begin
      if (link_q)            wb_data = pc_plus8_q;
      else if (mem_to_reg_q) wb_data = load_value;
      else                   wb_data = alu_result_q;
    end
  end

  assign fwd_valid   = wb_we;
  assign fwd_address = wb_address;
  assign fwd_data    = wb_data;

`ifdef WB_PERF_EN
  logic [31:0] retired_q, retired_d;

  assign retired_d = retired_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_d;
  end

  assign retired_count = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed scoreboard bench for mem_wb_writeback; counter expectations follow WB_PERF_EN.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        in_valid, in_reg_write, in_mem_to_reg, in_link;
  logic [1:0]  in_load_size, in_byte_offset;
  logic        in_load_unsigned;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus8;
  logic [4:0]  in_dest;
  logic        wb_we, fwd_valid;
  logic [4:0]  wb_address, fwd_address;
  logic [31:0] wb_data, fwd_data, retired_count;

  always #5 clk = ~clk;

  mem_wb_writeback #(.DATA_WIDTH(32), .REGFILE_WIDTH(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_reg_write     (in_reg_write),
    .in_mem_to_reg    (in_mem_to_reg),
    .in_link          (in_link),
    .in_load_size     (in_load_size),
    .in_load_unsigned (in_load_unsigned),
    .in_byte_offset   (in_byte_offset),
    .in_alu_result    (in_alu_result),
    .in_mem_data      (in_mem_data),
    .in_pc_plus8      (in_pc_plus8),
    .in_dest          (in_dest),
    .wb_we            (wb_we),
    .wb_address       (wb_address),
    .wb_data          (wb_data),
    .fwd_valid        (fwd_valid),
    .fwd_address      (fwd_address),
    .fwd_data         (fwd_data),
    .retired_count    (retired_count)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t         sb[$];
  wb_t         held;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_cnt;
  bit          m_valid, m_fired;

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] sz, logic [1:0] off, logic uns);
    logic [31:0] sh;
    case (sz)
      2'b10: begin
        sh = w >> (8 * (3 - int'(off)));
        return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = off[1] ? w : (w >> 16);
        return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: return w;
    endcase
  endfunction

  function automatic wb_t ref_wb();
    wb_t r;
    r = '0;
    if (in_valid) begin
      r.we   = in_reg_write && (in_dest != 5'd0);
      r.addr = in_dest;
      if (in_link)            r.data = in_pc_plus8;
      else if (in_mem_to_reg) r.data = ref_load(in_mem_data, in_load_size, in_byte_offset, in_load_unsigned);
      else                    r.data = in_alu_result;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(bit v, bit rw, bit m2r, bit lk, logic [1:0] sz, bit uns, logic [1:0] off,
                        logic [31:0] alu, logic [31:0] mem, logic [31:0] pc8, logic [4:0] dest);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_link = lk;
    in_load_size = sz; in_load_unsigned = uns; in_byte_offset = off;
    in_alu_result = alu; in_mem_data = mem; in_pc_plus8 = pc8; in_dest = dest;
  endtask

  // Predicts the stage after the coming edge, pushes it, then checks the DUT against it.
  task automatic cycle(string tag);
    wb_t nxt, exp;
    if (reset) begin
      nxt = '0; m_valid = 0; m_fired = 0; exp_cnt = '0;
    end else begin
      if (m_valid && !m_fired) exp_cnt = exp_cnt + 32'd1;
      if (flush) begin
        nxt = '0; m_valid = 0; m_fired = 0;
      end else if (stall) begin
        nxt = held; nxt.we = 1'b0;
        if (m_valid) m_fired = 1;
      end else begin
        nxt = ref_wb(); m_valid = in_valid; m_fired = 0;
      end
    end
    held = nxt;
    sb.push_back(nxt);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_we"},   {31'h0, wb_we},        {31'h0, exp.we});
      chk({tag, "_addr"}, {27'h0, wb_address},   {27'h0, exp.addr});
      chk({tag, "_data"}, wb_data,               exp.data);
      chk({tag, "_fv"},   {31'h0, fwd_valid},    {31'h0, exp.we});
      chk({tag, "_fa"},   {27'h0, fwd_address},  {27'h0, exp.addr});
      chk({tag, "_fd"},   fwd_data,              exp.data);
`ifdef WB_PERF_EN
      chk({tag, "_cnt"},  retired_count,         exp_cnt);
`else
      chk({tag, "_cnt"},  retired_count,         32'h0);
`endif
    end
    $display("[TB] %s we=%0b addr=%0d data=0x%08h cnt=%0d", tag, wb_we, wb_address, wb_data, retired_count);
  endtask

  localparam logic [31:0] MEMW = 32'h80FF7F01;

  initial begin
    reset = 1; stall = 0; flush = 0; exp_cnt = '0; held = '0;
    set_in(0, 0, 0, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    cycle("reset0");
    cycle("reset1");
    reset = 0;

    set_in(1, 1, 0, 0, 2'b00, 0, 2'd0, 32'h12345678, 32'h0, 32'h0, 5'd8);
    cycle("alu");
    chk("alu_const", wb_data, 32'h12345678);

    set_in(1, 1, 1, 0, 2'b10, 0, 2'd0, 32'hDEADBEEF, MEMW, 32'h0, 5'd9);
    cycle("lb0");
    chk("lb0_const", wb_data, 32'hFFFFFF80);
    set_in(1, 1, 1, 0, 2'b10, 0, 2'd2, 32'hDEADBEEF, MEMW, 32'h0, 5'd9);
    cycle("lb2");
    chk("lb2_const", wb_data, 32'h0000007F);
    set_in(1, 1, 1, 0, 2'b10, 1, 2'd1, 32'hDEADBEEF, MEMW, 32'h0, 5'd10);
    cycle("lbu1");
    chk("lbu1_const", wb_data, 32'h000000FF);
    set_in(1, 1, 1, 0, 2'b10, 0, 2'd3, 32'hDEADBEEF, MEMW, 32'h0, 5'd10);
    cycle("lb3");
    set_in(1, 1, 1, 0, 2'b01, 0, 2'd2, 32'hDEADBEEF, MEMW, 32'h0, 5'd11);
    cycle("lh2");
    chk("lh2_const", wb_data, 32'h00007F01);
    set_in(1, 1, 1, 0, 2'b01, 0, 2'd0, 32'hDEADBEEF, MEMW, 32'h0, 5'd11);
    cycle("lh0");
    chk("lh0_const", wb_data, 32'hFFFF80FF);
    set_in(1, 1, 1, 0, 2'b01, 1, 2'd1, 32'hDEADBEEF, MEMW, 32'h0, 5'd11);
    cycle("lhu1");
    set_in(1, 1, 1, 0, 2'b00, 0, 2'd3, 32'hDEADBEEF, MEMW, 32'h0, 5'd12);
    cycle("lw3");
    set_in(1, 1, 1, 0, 2'b11, 1, 2'd1, 32'hDEADBEEF, MEMW, 32'h0, 5'd12);
    cycle("lw11");
    chk("lw11_const", wb_data, MEMW);

    set_in(1, 1, 0, 0, 2'b00, 0, 2'd0, 32'h55AA55AA, 32'h0, 32'h0, 5'd0);
    cycle("dest0");

    set_in(1, 1, 0, 0, 2'b00, 0, 2'd0, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd13);
    cycle("st_cap");
    stall = 1;
    set_in(1, 1, 0, 0, 2'b00, 0, 2'd0, 32'h11111111, 32'h0, 32'h0, 5'd3);
    cycle("st1");
    cycle("st2");
    cycle("st3");
    chk("st_hold_const", wb_data, 32'hA5A5A5A5);
    stall = 0;
    set_in(0, 0, 0, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    cycle("st_end");

    set_in(1, 1, 0, 0, 2'b00, 0, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 5'd5);
    cycle("fl_cap");
    flush = 1; stall = 1;
    cycle("flush");
    flush = 0; stall = 0;
    set_in(0, 0, 0, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    cycle("fl_idle");

    set_in(1, 1, 1, 1, 2'b10, 0, 2'd0, 32'h00000001, MEMW, 32'h00400010, 5'd31);
    cycle("jal");
    chk("jal_const", wb_data, 32'h00400010);

    set_in(0, 1, 0, 0, 2'b00, 0, 2'd0, 32'h0000FFFF, 32'h0, 32'h0, 5'd7);
    cycle("invalid");

    set_in(1, 1, 0, 0, 2'b00, 0, 2'd0, 32'h00000077, 32'h0, 32'h0, 5'd4);
    cycle("rs_cap");
    stall = 1;
    cycle("rs_stall");
    reset = 1;
    cycle("rs_reset");
    reset = 0; stall = 0;
    set_in(0, 0, 0, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    cycle("rs_idle");

`ifdef WB_PERF_EN
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    exp_cnt = 32'hFFFFFFFF;
    set_in(1, 0, 0, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd1);
    cycle("wrap_cap");
    set_in(0, 0, 0, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    cycle("wrap");
    chk("wrap_const", retired_count, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
